echo_distance_filter: RTL
=========================

Name: echo_distance_filter

Overview:
Downstream stage of the ultrasonic ranging block. Captures each completed echo cycle count and converts it to centimetres with a sequential shift-subtract divider. Smooths the result with a 4-tap moving average and flags near objects. Feeds the navigation/display logic with one validated distance per echo.

Parameters:
COUNT_WIDTH, 23, width of incoming echo cycle count
DIST_WIDTH, 12, width of distance outputs in cm
CYCLES_PER_CM, 2900, clk cycles per cm of range (50 MHz, 58 us/cm)
MAX_CM, 400, saturation limit; larger results are out of range
NEAR_CM, 20, near threshold in cm
AVG_LOG2, 2, log2 of moving-average depth (fixed taps = 1<<AVG_LOG2)

Ports:
clk  in  1  system clock, 50 MHz
reset_all  in  1  asynchronous active-low reset
count_in  in  COUNT_WIDTH  echo length in clk cycles from the ranging block
count_ready_in  in  1  high while count_in is stable (echo low)
enable_in  in  1  capture permitted when high
distance_raw_out  out  DIST_WIDTH  latest converted distance, saturated
distance_avg_out  out  DIST_WIDTH  moving-average distance
distance_valid_out  out  1  one-cycle pulse when both distances update
near_out  out  1  distance_avg_out < NEAR_CM
out_of_range_out  out  1  latest raw quotient > MAX_CM
overrun_out  out  1  sticky: a capture edge arrived while busy
busy_out  out  1  FSM not in S_IDLE

Behaviour:
- Reset (reset_all low, async): all outputs 0, FSM to S_IDLE, taps cleared, fill flag cleared, ready_q cleared. Reset mid-divide aborts with no valid pulse.
- Edge detect: ready_q <= count_ready_in each cycle. Capture event = count_ready_in & ~ready_q & enable_in.
- S_IDLE: on capture event, latch count_in into the dividend register, then go to S_DIVIDE.
- S_DIVIDE: restoring divide by CYCLES_PER_CM, one quotient bit per cycle, MSB first, exactly COUNT_WIDTH cycles. Then go to S_FILTER.
- S_FILTER (1 cycle):
  - If quotient > MAX_CM: raw = MAX_CM, out_of_range = 1. Otherwise raw = quotient[DIST_WIDTH-1:0], out_of_range = 0.
  - Shift raw into the tap line. If this is the first sample since reset, load all taps with raw.
  - Go to S_OUTPUT.
- S_OUTPUT (1 cycle):
  - avg = (sum of taps) >> AVG_LOG2, truncating. Sum width is DIST_WIDTH+AVG_LOG2, no overflow.
  - Register distance_raw_out, distance_avg_out, near_out and out_of_range_out.
  - Pulse distance_valid_out.
  - Return to S_IDLE.
- Latency: capture edge sampled at cycle t gives distance_valid_out high at cycle t+COUNT_WIDTH+3 (26 at default). Outputs hold their values between pulses.
- Capture event while not in S_IDLE: event dropped, overrun_out set to 1. It clears only on reset.
- count_ready_in held high does not re-trigger; a new 0->1 edge is required.
- count_in = 0 gives distance 0; it is still a valid sample.
- count_in = all ones is handled by saturation to MAX_CM.
- enable_in low suppresses new captures but never aborts an operation in flight.

Decomposition:
- Package ultrasonic_pkg holds:
  - state typedef (S_IDLE, S_DIVIDE, S_FILTER, S_OUTPUT)
  - CLK_HZ = 50_000_000
  - US_PER_CM = 58
  - default CYCLES_PER_CM derived from CLK_HZ and US_PER_CM
- One sub-module: seq_divider.
  - Parameterised width, constant divisor.
  - start/busy/done handshake; done is a one-cycle pulse.
  - Outputs quotient and remainder.
- The top module owns the edge detector, FSM, tap line, averaging and flags.

Test Plan:
- count_in=29000, ready edge -> after 26 cycles valid pulse; raw=10, avg=10, near=1, out_of_range=0.
- Sequence 29000, 58000, 87000, 116000 -> raw 10, 20, 30, 40; avg 10, 12, 17, 25; near 1, 1, 1, 0.
- count_in=2899 -> raw=0, avg=0. count_in=5800000 -> raw=400, out_of_range=1.
- Second ready edge 10 cycles after the first -> first result delivered unchanged, second dropped, overrun_out=1 and stays 1.
- reset_all pulsed low at cycle 12 of a divide -> no valid pulse, all outputs 0. The next sample 58000 gives avg=20, because taps are refilled on the first sample.
- enable_in=0 during edge -> no capture, busy_out stays 0. count_ready_in held high, then enable_in raised -> still no capture until a fresh edge.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and timing constants for the ultrasonic ranging pipeline.
package ultrasonic_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned US_PER_CM = 58;
  localparam int unsigned CYCLES_PER_CM_DEFAULT = (CLK_HZ / 1_000_000) * US_PER_CM;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FILTER,
    S_OUTPUT
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider by a constant, one quotient bit per cycle, MSB first.
module seq_divider #(
  parameter int unsigned WIDTH   = 23,
  parameter int unsigned DIVISOR = 2900
) (
  input  logic             clk,
  input  logic             reset_all,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned RW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [RW:0] DIV = (RW+1)'(DIVISOR);

  logic [RW-1:0]    rem, rem_src, rem_next;
  logic [WIDTH-1:0] quo, quo_src, quo_next;
  logic [RW:0]      trial, trial_diff;
  logic [CW-1:0]    cnt;

  // The first step is taken on the start edge itself, so a full divide
  // occupies exactly WIDTH clock edges and done follows the last one.
  always_comb begin
    rem_src    = start ? '0 : rem;
    quo_src    = start ? dividend : quo;
    trial      = {rem_src, quo_src[WIDTH-1]};
    trial_diff = trial - DIV;
    if (trial >= DIV) begin
      rem_next = trial_diff[RW-1:0];
      quo_next = {quo_src[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = trial[RW-1:0];
      quo_next = {quo_src[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= CW'(1);
        if (WIDTH == 1) begin
          done <= 1'b1;
        end else begin
          busy <= 1'b1;
        end
      end else if (busy) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = WIDTH'(rem);

endmodule

// File: rtl/echo_distance_filter.sv
// Converts captured echo cycle counts to centimetres, saturates, averages over
// a short tap line and flags near objects; one validated distance per echo.
module echo_distance_filter
  import ultrasonic_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH   = 23,
  parameter int unsigned DIST_WIDTH    = 12,
  parameter int unsigned CYCLES_PER_CM = CYCLES_PER_CM_DEFAULT,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned NEAR_CM       = 20,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                   clk,
  input  logic                   reset_all,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   count_ready_in,
  input  logic                   enable_in,
  output logic [DIST_WIDTH-1:0]  distance_raw_out,
  output logic [DIST_WIDTH-1:0]  distance_avg_out,
  output logic                   distance_valid_out,
  output logic                   near_out,
  output logic                   out_of_range_out,
  output logic                   overrun_out,
  output logic                   busy_out
);

  localparam int unsigned TAPS = 1 << AVG_LOG2;
  localparam int unsigned SW   = DIST_WIDTH + AVG_LOG2;

  state_t state, state_next;

  logic                   ready_q;
  logic                   capture;
  logic                   div_start;
  logic                   div_done;
  logic                   div_busy_unused;
  logic [COUNT_WIDTH-1:0] quotient;
  logic [COUNT_WIDTH-1:0] div_rem_unused;

  logic [DIST_WIDTH-1:0]  taps [TAPS];
  logic                   filled;
  logic                   oor_q;
  logic                   oor_now;
  logic [DIST_WIDTH-1:0]  raw_sat;
  logic [SW-1:0]          sum;
  logic [SW-1:0]          avg_full;
  logic [DIST_WIDTH-1:0]  avg;

  seq_divider #(
    .WIDTH   (COUNT_WIDTH),
    .DIVISOR (CYCLES_PER_CM)
  ) u_div (
    .clk       (clk),
    .reset_all (reset_all),
    .start     (div_start),
    .dividend  (count_in),
    .busy      (div_busy_unused),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (div_rem_unused)
  );

  always_comb begin
    capture    = count_ready_in & ~ready_q & enable_in;
    div_start  = 1'b0;
    state_next = state;
    case (state)
      S_IDLE: begin
        if (capture) begin
          div_start  = 1'b1;
          state_next = S_DIVIDE;
        end
      end
      S_DIVIDE: if (div_done) state_next = S_FILTER;
      S_FILTER: state_next = S_OUTPUT;
      S_OUTPUT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    oor_now = quotient > COUNT_WIDTH'(MAX_CM);
    raw_sat = oor_now ? DIST_WIDTH'(MAX_CM) : quotient[DIST_WIDTH-1:0];
    sum     = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      sum = sum + SW'(taps[i]);
    end
    avg_full = sum >> AVG_LOG2;
    avg      = avg_full[DIST_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= count_ready_in;
    end
  end

  // taps[0] always holds the latest saturated sample, so it doubles as the raw result.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        taps[i] <= '0;
      end
      filled             <= 1'b0;
      oor_q              <= 1'b0;
      distance_raw_out   <= '0;
      distance_avg_out   <= '0;
      distance_valid_out <= 1'b0;
      near_out           <= 1'b0;
      out_of_range_out   <= 1'b0;
      overrun_out        <= 1'b0;
    end else begin
      distance_valid_out <= 1'b0;
      if (capture && state != S_IDLE) begin
        overrun_out <= 1'b1;
      end
      if (state == S_FILTER) begin
        oor_q  <= oor_now;
        filled <= 1'b1;
        taps[0] <= raw_sat;
        for (int unsigned i = 1; i < TAPS; i++) begin
          taps[i] <= filled ? taps[i-1] : raw_sat;
        end
      end
      if (state == S_OUTPUT) begin
        distance_raw_out   <= taps[0];
        distance_avg_out   <= avg;
        near_out           <= avg < DIST_WIDTH'(NEAR_CM);
        out_of_range_out   <= oor_q;
        distance_valid_out <= 1'b1;
      end
    end
  end

  assign busy_out = (state != S_IDLE);

endmodule
